// File: rtl/scan_mux_pkg.sv
// Shared types for the scan_mux block: controller states and mode encodings.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/next_ch_find.sv
// Combinational search for the next set mask bit strictly above cur, wrapping to the lowest set bit.
module next_ch_find
  import scan_mux_pkg::*;
#(
  parameter int NCH = 16,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] nxt,
  output logic            wrapped,
  output logic            none
);

  logic [SELW-1:0] lo_ch;
  logic [SELW-1:0] hi_ch;
  logic            hi_found;

  // Descending walk so the last hit in each class is the lowest qualifying index.
  always_comb begin
    lo_ch    = '0;
    hi_ch    = '0;
    hi_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lo_ch = SELW'(k);
        if (k > int'(cur)) begin
          hi_ch    = SELW'(k);
          hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    none    = (mask == '0);
    nxt     = hi_found ? hi_ch : lo_ch;
    wrapped = !hi_found && !none;
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N-channel mux with manual select and masked auto-scan (dwell counter, wrap pulse).
// Outputs are registered one cycle after the selecting input; scan data is re-sampled every cycle.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int WIDTH = 1,
  parameter int DWELL = 1,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  input  logic [NCH-1:0]       mask,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      ch_out,
  output logic                 dout_valid,
  output logic                 wrap
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t          state, state_nxt;
  logic [SELW-1:0] cur, cur_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic            wrap_pend, wrap_pend_d;
  logic            restart, restart_d;
  logic [WIDTH-1:0] dout_d;
  logic [SELW-1:0] ch_out_d;
  logic            valid_d, wrap_d;

  logic [SELW-1:0] low_ch, adv_ch, eff;
  logic [CNTW-1:0] eff_cnt;
  logic            eff_wp, low_none, low_wrapped, adv_wrapped, adv_none;
  logic            unused_flags;

  function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] d,
                                            input logic [SELW-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  next_ch_find #(.NCH(NCH)) u_find_low (
    .mask    (mask),
    .cur     (SELW'(NCH - 1)),
    .nxt     (low_ch),
    .wrapped (low_wrapped),
    .none    (low_none)
  );

  // After entry or an all-zero mask, the scan resumes from the lowest set bit in the same cycle.
  always_comb begin
    eff     = restart ? low_ch : cur;
    eff_cnt = restart ? '0 : cnt;
    eff_wp  = restart ? 1'b0 : wrap_pend;
  end

  next_ch_find #(.NCH(NCH)) u_find_adv (
    .mask    (mask),
    .cur     (eff),
    .nxt     (adv_ch),
    .wrapped (adv_wrapped),
    .none    (adv_none)
  );

  assign unused_flags = low_wrapped ^ adv_none;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      wrap_pend  <= 1'b0;
      restart    <= 1'b0;
      dout       <= '0;
      ch_out     <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_d;
      cnt        <= cnt_d;
      wrap_pend  <= wrap_pend_d;
      restart    <= restart_d;
      dout       <= dout_d;
      ch_out     <= ch_out_d;
      dout_valid <= valid_d;
      wrap       <= wrap_d;
    end
  end

  always_comb begin
    if (!en)                    state_nxt = IDLE;
    else if (mode == MODE_SCAN) state_nxt = SCAN;
    else                        state_nxt = MANUAL;
  end

  always_comb begin
    dout_d      = dout;
    ch_out_d    = ch_out;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;
    cur_d       = cur;
    cnt_d       = '0;
    wrap_pend_d = wrap_pend;
    restart_d   = restart;
    case (state_nxt)
      MANUAL: begin
        ch_out_d = sel;
        if (int'(sel) < NCH) begin
          dout_d  = pick(din, sel);
          valid_d = 1'b1;
        end else begin
          dout_d = '0;
        end
      end
      SCAN: begin
        if (state != SCAN) begin
          cur_d       = low_ch;
          wrap_pend_d = 1'b0;
          restart_d   = 1'b1;
        end else if (low_none) begin
          cnt_d     = cnt;
          restart_d = 1'b1;
        end else begin
          dout_d    = pick(din, eff);
          ch_out_d  = eff;
          valid_d   = mask[eff];
          // A pass start on a channel masked mid-dwell is not announced.
          wrap_d    = eff_wp && mask[eff];
          restart_d = 1'b0;
          if (eff_cnt == CNTW'(DWELL - 1)) begin
            cur_d       = adv_ch;
            wrap_pend_d = adv_wrapped;
          end else begin
            cur_d       = eff;
            cnt_d       = eff_cnt + 1'b1;
            wrap_pend_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 16x1 DWELL=2 instance and a 12x4 DWELL=1 instance.
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] din_a;
  logic [3:0]  sel_a;
  logic        mode_a, en_a;
  logic [15:0] mask_a;
  logic [0:0]  dout_a;
  logic [3:0]  ch_a;
  logic        valid_a, wrap_a;

  logic [47:0] din_b;
  logic [3:0]  sel_b;
  logic        mode_b, en_b;
  logic [11:0] mask_b;
  logic [3:0]  dout_b;
  logic [3:0]  ch_b;
  logic        valid_b, wrap_b;

  always #5 clk = ~clk;

  scan_mux #(.NCH(16), .WIDTH(1), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .mode(mode_a), .en(en_a),
    .mask(mask_a), .dout(dout_a), .ch_out(ch_a), .dout_valid(valid_a), .wrap(wrap_a)
  );

  scan_mux #(.NCH(12), .WIDTH(4), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .mode(mode_b), .en(en_b),
    .mask(mask_b), .dout(dout_b), .ch_out(ch_b), .dout_valid(valid_b), .wrap(wrap_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // din_a = 16'h3333: channel k carries 1 when k mod 4 is 0 or 1.
  function automatic logic [31:0] bit_a(input int k);
    return ((k % 4) < 2) ? 32'd1 : 32'd0;
  endfunction

  initial begin
    logic [31:0] wrap_exp[6];
    logic [31:0] ch_exp[6];
    logic [31:0] d_exp[6];

    rst = 1'b1;
    din_a = 16'h3333; sel_a = '0; mode_a = 1'b0; en_a = 1'b0; mask_a = '0;
    din_b = 48'hCBA987654321; sel_b = '0; mode_b = 1'b0; en_b = 1'b0; mask_b = '0;
    tick();
    chk("rst_dout_a", 32'(dout_a), 0);
    chk("rst_ch_a", 32'(ch_a), 0);
    chk("rst_valid_a", 32'(valid_a), 0);
    chk("rst_wrap_a", 32'(wrap_a), 0);
    chk("rst_dout_b", 32'(dout_b), 0);
    chk("rst_valid_b", 32'(valid_b), 0);
    rst = 1'b0;

    en_a = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel_a = 4'(s);
      tick();
      chk("man_dout", 32'(dout_a), bit_a(s));
      chk("man_ch", 32'(ch_a), 32'(s));
      chk("man_valid", 32'(valid_a), 1);
    end

    mask_a = 16'hFFFF; mode_a = 1'b1;
    tick();
    chk("scan_entry_valid", 32'(valid_a), 0);
    chk("scan_entry_wrap", 32'(wrap_a), 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("scan_ch", 32'(ch_a), 32'(i / 2));
      chk("scan_dout", 32'(dout_a), bit_a(i / 2));
      chk("scan_valid", 32'(valid_a), 1);
      chk("scan_wrap", 32'(wrap_a), 0);
    end
    tick();
    chk("scan_ret_ch", 32'(ch_a), 0);
    chk("scan_ret_wrap", 32'(wrap_a), 1);
    tick();
    chk("scan_ret2_ch", 32'(ch_a), 0);
    chk("scan_ret2_wrap", 32'(wrap_a), 0);

    mask_a = 16'h0000;
    tick();
    chk("mask0_valid", 32'(valid_a), 0);
    chk("mask0_ch_hold", 32'(ch_a), 0);
    chk("mask0_dout_hold", 32'(dout_a), 1);
    chk("mask0_wrap", 32'(wrap_a), 0);
    tick();
    chk("mask0_valid2", 32'(valid_a), 0);

    mask_a = 16'h8000;
    wrap_exp = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("single_ch", 32'(ch_a), 15);
      chk("single_dout", 32'(dout_a), bit_a(15));
      chk("single_valid", 32'(valid_a), 1);
      chk("single_wrap", 32'(wrap_a), wrap_exp[i]);
    end

    en_a = 1'b0;
    tick();
    chk("dis_valid", 32'(valid_a), 0);
    chk("dis_ch_hold", 32'(ch_a), 15);
    chk("dis_dout_hold", 32'(dout_a), 0);

    mask_a = 16'hFFFF; en_a = 1'b1;
    tick();
    chk("reen_valid", 32'(valid_a), 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("reen_ch", 32'(ch_a), 32'(i / 2));
      chk("reen_valid", 32'(valid_a), 1);
    end
    rst = 1'b1;
    tick();
    chk("midrst_dout", 32'(dout_a), 0);
    chk("midrst_ch", 32'(ch_a), 0);
    chk("midrst_valid", 32'(valid_a), 0);
    chk("midrst_wrap", 32'(wrap_a), 0);
    rst = 1'b0; en_a = 1'b0;
    tick();
    chk("post_rst_idle_valid", 32'(valid_a), 0);

    en_b = 1'b1; mode_b = 1'b0; sel_b = 4'd13;
    tick();
    chk("oor_dout", 32'(dout_b), 0);
    chk("oor_valid", 32'(valid_b), 0);
    chk("oor_ch", 32'(ch_b), 13);
    sel_b = 4'd3;
    tick();
    chk("sel3_dout", 32'(dout_b), 4);
    chk("sel3_valid", 32'(valid_b), 1);
    chk("sel3_ch", 32'(ch_b), 3);
    sel_b = 4'd11;
    tick();
    chk("sel11_dout", 32'(dout_b), 32'hC);

    mask_b = 12'h011; mode_b = 1'b1;
    tick();
    chk("sparse_entry_valid", 32'(valid_b), 0);
    chk("sparse_entry_dout_hold", 32'(dout_b), 32'hC);
    ch_exp   = '{32'd0, 32'd4, 32'd0, 32'd4, 32'd0, 32'd4};
    d_exp    = '{32'd1, 32'd5, 32'd1, 32'd5, 32'd1, 32'd5};
    wrap_exp = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sparse_ch", 32'(ch_b), ch_exp[i]);
      chk("sparse_dout", 32'(dout_b), d_exp[i]);
      chk("sparse_valid", 32'(valid_b), 1);
      chk("sparse_wrap", 32'(wrap_b), wrap_exp[i]);
    end

    mask_b = 12'h010;
    tick();
    chk("masked_cur_ch", 32'(ch_b), 0);
    chk("masked_cur_valid", 32'(valid_b), 0);
    chk("masked_cur_wrap", 32'(wrap_b), 0);
    tick();
    chk("remask_ch", 32'(ch_b), 4);
    chk("remask_valid", 32'(valid_b), 1);
    chk("remask_wrap", 32'(wrap_b), 0);
    tick();
    chk("remask_ch2", 32'(ch_b), 4);
    chk("remask_wrap2", 32'(wrap_b), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
